// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment frame reader.
// Patterns are active-low {a,b,c,d,e,f,g} with a at bit 6.
package seg7_pkg;

    localparam int unsigned SEG_W = 7;

    typedef logic [SEG_W-1:0] seg_t;

    localparam seg_t SEG_0     = 7'b0000001;
    localparam seg_t SEG_1     = 7'b1001111;
    localparam seg_t SEG_2     = 7'b0010010;
    localparam seg_t SEG_3     = 7'b0000110;
    localparam seg_t SEG_4     = 7'b1001100;
    localparam seg_t SEG_5     = 7'b0100100;
    localparam seg_t SEG_6     = 7'b0100000;
    localparam seg_t SEG_7     = 7'b0001111;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_BLANK = 7'b1111111;
    localparam seg_t SEG_MINUS = 7'b1111110;

    typedef enum logic {
        S_MAG,
        S_SIGN
    } state_e;

endpackage

// File: rtl/seg7_frame_reader_if.sv
// Scanned segment bus plus decoded readback outputs of seg7_frame_reader.
// master drives the segment bus; slave is the reader.
interface seg7_frame_reader_if;

    seg7_pkg::seg_t seg_n;
    logic           dig;
    logic           seg_stb;
    logic [3:0]     value;
    logic           value_vld;
    logic           err;
    logic           locked;
    logic           stale;

    modport master (
        output seg_n, dig, seg_stb,
        input  value, value_vld, err, locked, stale
    );

    modport slave (
        input  seg_n, dig, seg_stb,
        output value, value_vld, err, locked, stale
    );

endinterface

// File: rtl/seg7_digit_dec.sv
// Combinational decode of one active-low 7-segment digit to a magnitude 0..8.
// legal_o is low for any pattern outside the encoder's digit set.
module seg7_digit_dec
    import seg7_pkg::*;
(
    input  seg_t       seg_i,
    output logic [3:0] mag_o,
    output logic       legal_o
);

    always_comb begin
        mag_o   = 4'd0;
        legal_o = 1'b1;
        case (seg_i)
            SEG_0:   mag_o = 4'd0;
            SEG_1:   mag_o = 4'd1;
            SEG_2:   mag_o = 4'd2;
            SEG_3:   mag_o = 4'd3;
            SEG_4:   mag_o = 4'd4;
            SEG_5:   mag_o = 4'd5;
            SEG_6:   mag_o = 4'd6;
            SEG_7:   mag_o = 4'd7;
            SEG_8:   mag_o = 4'd8;
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_frame_reader.sv
// Recovers a 4-bit two's-complement value from sign+magnitude 7-segment frames,
// with stability filtering. Optional watchdog enabled by SEG7_RD_TIMEOUT_EN.
module seg7_frame_reader
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CNT  = 3,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    seg7_frame_reader_if.slave  bus
);

    localparam logic [3:0] StableCnt = 4'(STABLE_CNT);

    if (STABLE_CNT < 1 || STABLE_CNT > 15 || TIMEOUT_CYC < 1) begin : g_cfg_check
        $error("seg7_frame_reader: STABLE_CNT must be 1..15 and TIMEOUT_CYC >= 1");
    end

    state_e     state_q, state_d;
    seg_t       mag_q, mag_d;
    logic [3:0] run_q, run_d;
    logic [3:0] cand_q, cand_d;
    logic [3:0] value_q, value_d;
    logic       vld_q, vld_d;
    logic       err_q, err_d;
    logic       locked_q, locked_d;

    logic [3:0] dec_mag;
    logic       dec_legal;
    logic       frame_done, sign_pos, sign_neg, frame_legal, same_cand, first_reach;
    logic [3:0] frame_val;
    logic       timeout;

    seg7_digit_dec u_mag_dec (
        .seg_i   (mag_q),
        .mag_o   (dec_mag),
        .legal_o (dec_legal)
    );

    assign frame_done  = bus.seg_stb && bus.dig && (state_q == S_SIGN);
    assign sign_pos    = (bus.seg_n == SEG_BLANK);
    assign sign_neg    = (bus.seg_n == SEG_MINUS);
    // Positive 8 and negative zero have no 4-bit two's-complement meaning.
    assign frame_legal = dec_legal && ((sign_pos && dec_mag != 4'd8) ||
                                       (sign_neg && dec_mag != 4'd0));
    assign frame_val   = sign_neg ? (~dec_mag + 4'd1) : dec_mag;
    assign same_cand   = (frame_val == cand_q);

    always_comb begin
        state_d     = state_q;
        mag_d       = mag_q;
        run_d       = run_q;
        cand_d      = cand_q;
        value_d     = value_q;
        vld_d       = 1'b0;
        err_d       = 1'b0;
        locked_d    = locked_q;
        first_reach = 1'b0;

        if (bus.seg_stb) begin
            if (!bus.dig) begin
                mag_d   = bus.seg_n;
                state_d = S_SIGN;
            end else if (state_q == S_SIGN) begin
                state_d = S_MAG;
            end
        end

        if (frame_done) begin
            if (!frame_legal) begin
                err_d    = 1'b1;
                run_d    = 4'd0;
                locked_d = 1'b0;
            end else begin
                if (same_cand) begin
                    run_d = (run_q == StableCnt) ? run_q : run_q + 4'd1;
                end else begin
                    cand_d = frame_val;
                    run_d  = 4'd1;
                end
                locked_d = (run_d == StableCnt);
                // A saturated run of the same candidate is not a new arrival.
                first_reach = (run_d == StableCnt) && !(same_cand && run_q == StableCnt);
                if (first_reach && cand_d != value_q) begin
                    value_d = cand_d;
                    vld_d   = 1'b1;
                end
            end
        end else if (timeout) begin
            run_d    = 4'd0;
            locked_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_MAG;
            mag_q    <= SEG_BLANK;
            run_q    <= 4'd0;
            cand_q   <= 4'd0;
            value_q  <= 4'd0;
            vld_q    <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mag_q    <= mag_d;
            run_q    <= run_d;
            cand_q   <= cand_d;
            value_q  <= value_d;
            vld_q    <= vld_d;
            err_q    <= err_d;
            locked_q <= locked_d;
        end
    end

`ifdef SEG7_RD_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYC);

    logic [CntW-1:0] wd_q, wd_d;
    logic            stale_q, stale_d;

    always_comb begin
        wd_d    = wd_q;
        stale_d = stale_q;
        timeout = 1'b0;
        if (frame_done) begin
            wd_d = '0;
            if (frame_legal) stale_d = 1'b0;
        end else if (wd_q != CntMax) begin
            wd_d    = wd_q + 1'b1;
            timeout = (wd_d == CntMax);
            if (timeout) stale_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q    <= '0;
            stale_q <= 1'b0;
        end else begin
            wd_q    <= wd_d;
            stale_q <= stale_d;
        end
    end

    assign bus.stale = stale_q;
`else
    assign timeout   = 1'b0;
    assign bus.stale = 1'b0;
`endif

    assign bus.value     = value_q;
    assign bus.value_vld = vld_q;
    assign bus.err       = err_q;
    assign bus.locked    = locked_q;

endmodule

// File: tb/tb_seg7_frame_reader.sv
// Randomized self-checking bench for seg7_frame_reader against a frame-history
// reference model; watchdog scenario runs when SEG7_RD_TIMEOUT_EN is defined.
module tb_seg7_frame_reader;

    localparam int unsigned StableCnt = 3;
`ifdef SEG7_RD_TIMEOUT_EN
    localparam int unsigned TimeoutCyc = 16;
`else
    localparam int unsigned TimeoutCyc = 1024;
`endif
    localparam logic [6:0] Blank = 7'b1111111;
    localparam logic [6:0] Minus = 7'b1111110;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg7_frame_reader_if bus ();

    seg7_frame_reader #(
        .STABLE_CNT  (StableCnt),
        .TIMEOUT_CYC (TimeoutCyc)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] mag_tab [9] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000};

    // Model: length of trailing run of identical legal frames since last illegal frame.
    int m_streak, m_last, m_value;
    bit e_vld, e_err, e_locked;
    logic o_vld, o_err, o_locked, o_stale;
    logic [3:0] o_value;

    function automatic void ref_decode(input logic [6:0] mag, input logic [6:0] sgn,
                                       output bit legal, output int val);
        int m = -1;
        for (int i = 0; i < 9; i++) if (mag == mag_tab[i]) m = i;
        legal = 1'b0;
        val   = 0;
        if (m < 0) return;
        if (sgn == Blank && m <= 7) begin
            legal = 1'b1;
            val   = m;
        end else if (sgn == Minus && m >= 1) begin
            legal = 1'b1;
            val   = (16 - m) % 16;
        end
    endfunction

    function automatic void model_reset();
        m_streak = 0;
        m_last   = 0;
        m_value  = 0;
    endfunction

    function automatic void model_frame(input logic [6:0] mag, input logic [6:0] sgn);
        bit legal;
        int val;
        ref_decode(mag, sgn, legal, val);
        e_vld = 1'b0;
        e_err = !legal;
        if (!legal) begin
            m_streak = 0;
        end else begin
            if (m_streak > 0 && val == m_last) begin
                if (m_streak < 100) m_streak++;
            end else begin
                m_streak = 1;
            end
            m_last = val;
            if (m_streak == StableCnt && val != m_value) begin
                e_vld   = 1'b1;
                m_value = val;
            end
        end
        e_locked = (m_streak >= StableCnt);
    endfunction

    task automatic sample();
        o_vld    = bus.value_vld;
        o_err    = bus.err;
        o_locked = bus.locked;
        o_value  = bus.value;
        o_stale  = bus.stale;
    endtask

    // Strobes back to back: optional leading sign, optional garbage magnitude, then the frame.
    task automatic do_frame(input logic [6:0] mag, input logic [6:0] sgn,
                            input bit lead, input bit extra);
        if (lead) begin
            @(negedge clk);
            bus.seg_n = Minus; bus.dig = 1'b1; bus.seg_stb = 1'b1;
        end
        if (extra) begin
            @(negedge clk);
            bus.seg_n = 7'($urandom); bus.dig = 1'b0; bus.seg_stb = 1'b1;
        end
        @(negedge clk);
        bus.seg_n = mag; bus.dig = 1'b0; bus.seg_stb = 1'b1;
        @(negedge clk);
        bus.seg_n = sgn; bus.dig = 1'b1;
        @(negedge clk);
        bus.seg_stb = 1'b0;
        sample();
        model_frame(mag, sgn);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.seg_stb = 1'b0;
        @(negedge clk);
        sample();
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        n_tests++;
        if ({o_value, o_vld, o_err, o_locked, o_stale} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required 00000000",
                     {o_value, o_vld, o_err, o_locked, o_stale});
        end
    endtask

    task automatic test_stable_positive();
        for (int i = 0; i < 3; i++) begin
            do_frame(mag_tab[5], Blank, 1'b0, 1'b0);
            n_tests++;
            if (o_vld !== e_vld || o_err !== e_err || o_locked !== e_locked) begin
                n_fail++;
                $display("FAIL stable_pos[%0d]: vld/err/locked got %b%b%b required %b%b%b",
                         i, o_vld, o_err, o_locked, e_vld, e_err, e_locked);
            end
        end
        n_tests++;
        if (o_value !== 4'b0101 || o_vld !== 1'b1 || o_locked !== 1'b1) begin
            n_fail++;
            $display("FAIL stable_pos_value: value=%b vld=%b locked=%b required 0101 1 1",
                     o_value, o_vld, o_locked);
        end
    endtask

    task automatic test_negative();
        logic [6:0] mags [2] = '{7'b0000110, 7'b0000000};
        logic [3:0] want [2] = '{4'b1101, 4'b1000};
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 3; i++) do_frame(mags[k], Minus, 1'b0, 1'b0);
            n_tests++;
            if (o_value !== want[k] || o_vld !== 1'b1 || o_err !== 1'b0) begin
                n_fail++;
                $display("FAIL negative[%0d]: value=%b vld=%b err=%b required %b 1 0",
                         k, o_value, o_vld, o_err, want[k]);
            end
        end
    endtask

    task automatic test_illegal();
        do_frame(7'b0000000, Blank, 1'b0, 1'b0);
        n_tests++;
        if (o_err !== 1'b1 || o_vld !== 1'b0 || o_locked !== 1'b0 || o_value !== 4'b1000) begin
            n_fail++;
            $display("FAIL illegal_pos8: err=%b vld=%b locked=%b value=%b required 1 0 0 1000",
                     o_err, o_vld, o_locked, o_value);
        end
        do_frame(7'b0000001, Minus, 1'b0, 1'b0);
        n_tests++;
        if (o_err !== 1'b1 || o_value !== 4'b1000) begin
            n_fail++;
            $display("FAIL illegal_negzero: err=%b value=%b required 1 1000", o_err, o_value);
        end
        do_frame(7'b1110111, Blank, 1'b0, 1'b0);
        n_tests++;
        if (o_err !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_pattern: err=%b required 1", o_err);
        end
    endtask

    task automatic test_flicker();
        int seq [6] = '{3, 3, 4, 3, 3, 3};
        for (int i = 0; i < 6; i++) begin
            do_frame(mag_tab[seq[i]], Blank, 1'b0, 1'b0);
            n_tests++;
            if (o_vld !== (i == 5) || o_err !== 1'b0) begin
                n_fail++;
                $display("FAIL flicker[%0d]: vld=%b err=%b required %b 0", i, o_vld, o_err, i == 5);
            end
        end
        n_tests++;
        if (o_value !== 4'b0011) begin
            n_fail++;
            $display("FAIL flicker_value: value=%b required 0011", o_value);
        end
    endtask

    task automatic test_resync();
        for (int i = 0; i < 3; i++) begin
            do_frame(mag_tab[7], Blank, (i == 0), 1'b0);
            n_tests++;
            if (o_vld !== e_vld || o_err !== e_err || o_locked !== e_locked) begin
                n_fail++;
                $display("FAIL resync[%0d]: vld/err/locked got %b%b%b required %b%b%b",
                         i, o_vld, o_err, o_locked, e_vld, e_err, e_locked);
            end
        end
        n_tests++;
        if (o_value !== 4'b0111) begin
            n_fail++;
            $display("FAIL resync_value: value=%b required 0111", o_value);
        end
    endtask

    task automatic test_random();
        logic [6:0] mag, sgn;
        int r;
        mag = mag_tab[1];
        sgn = Blank;
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 9));
            if ($urandom_range(0, 1) == 0) begin
                // repeat previous frame to build runs
            end else if (r < 7) begin
                mag = mag_tab[$urandom_range(0, 3)];
                sgn = ($urandom_range(0, 1) != 0) ? Minus : Blank;
            end else if (r < 9) begin
                mag = mag_tab[$urandom_range(0, 8)];
                sgn = ($urandom_range(0, 1) != 0) ? Minus : Blank;
            end else begin
                mag = 7'($urandom);
                sgn = ($urandom_range(0, 1) != 0) ? 7'($urandom) : Blank;
            end
            do_frame(mag, sgn, ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
            n_tests++;
            if (o_vld !== e_vld || o_err !== e_err || o_locked !== e_locked ||
                o_value !== 4'(m_value)) begin
                n_fail++;
                $display("FAIL random[%0d] mag=%b sgn=%b: vld/err/locked/value got %b%b%b %b required %b%b%b %b",
                         n, mag, sgn, o_vld, o_err, o_locked, o_value,
                         e_vld, e_err, e_locked, 4'(m_value));
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        @(negedge clk);
        bus.seg_n = 7'b1111111; bus.dig = 1'b0; bus.seg_stb = 1'b1;
        @(negedge clk);
        bus.seg_stb = 1'b0;
        apply_reset();
        n_tests++;
        if ({o_value, o_vld, o_err, o_locked, o_stale} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got %b required 00000000",
                     {o_value, o_vld, o_err, o_locked, o_stale});
        end
        @(negedge clk);
        bus.seg_n = Blank; bus.dig = 1'b1; bus.seg_stb = 1'b1;
        @(negedge clk);
        bus.seg_stb = 1'b0;
        sample();
        n_tests++;
        if (o_err !== 1'b0 || o_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_discard: err=%b vld=%b required 0 0", o_err, o_vld);
        end
    endtask

    task automatic test_watchdog();
        for (int i = 0; i < 3; i++) do_frame(mag_tab[2], Blank, 1'b0, 1'b0);
        n_tests++;
        if (o_locked !== 1'b1 || o_value !== 4'b0010 || o_stale !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_lock: locked=%b value=%b stale=%b required 1 0010 0",
                     o_locked, o_value, o_stale);
        end
`ifdef SEG7_RD_TIMEOUT_EN
        repeat (TimeoutCyc) @(negedge clk);
        sample();
        m_streak = 0;
        n_tests++;
        if (o_stale !== 1'b1 || o_locked !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_stale: stale=%b locked=%b required 1 0", o_stale, o_locked);
        end
        do_frame(mag_tab[2], Blank, 1'b0, 1'b0);
        n_tests++;
        if (o_stale !== 1'b0 || o_vld !== 1'b0 || o_locked !== e_locked) begin
            n_fail++;
            $display("FAIL wd_clear: stale=%b vld=%b locked=%b required 0 0 %b",
                     o_stale, o_vld, o_locked, e_locked);
        end
`else
        repeat (40) @(negedge clk);
        sample();
        n_tests++;
        if (o_stale !== 1'b0 || o_locked !== 1'b1) begin
            n_fail++;
            $display("FAIL wd_absent: stale=%b locked=%b required 0 1", o_stale, o_locked);
        end
`endif
    endtask

    initial begin
        bus.seg_n   = Blank;
        bus.dig     = 1'b0;
        bus.seg_stb = 1'b0;
        model_reset();
        test_reset();
        test_stable_positive();
        test_negative();
        test_illegal();
        test_flicker();
        test_resync();
        test_random();
        test_reset_mid_frame();
        test_watchdog();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_frame_reader.md
# seg7_frame_reader

Recovers a 4-bit two's-complement value from the two-digit, active-low 7-segment frames produced by our display encoder: sign digit plus magnitude digit. It sits on the scanned segment bus in the debug/readback path. It checks every frame for legal patterns, requires a configurable number of identical consecutive frames before reporting, and flags illegal or stale displays.

## Interface
- `STABLE_CNT`, default 3: number of consecutive identical legal frames required before `value` updates. Allowed range is 1..15.
- `TIMEOUT_CYC`, default 1024: watchdog length in clocks. It is used only when `SEG7_RD_TIMEOUT_EN` is defined.
- `clk` in, 1: sole clock. All logic is on the rising edge.
- `rst_n` in, 1: asynchronous, active-low reset.
- `seg_n` in, 7: segment bus `{a,b,c,d,e,f,g}` with `a` at bit 6. A 0 means the segment is lit.
- `dig` in, 1: digit select qualifying `seg_n`. 0 = magnitude digit, 1 = sign digit.
- `seg_stb` in, 1: one-cycle strobe. `seg_n` and `dig` are valid in this cycle.
- `value` out, 4: last reported two's-complement value.
- `value_vld` out, 1: one-cycle pulse when `value` takes a new reported value.
- `err` out, 1: one-cycle pulse on each completed frame that is illegal.
- `locked` out, 1: high while the current frame run has reached `STABLE_CNT`.
- `stale` out, 1: watchdog flag. It is present only with the macro; otherwise it is tied 0.

## Operation
- **Frame assembly FSM**, states S_MAG and S_SIGN. Reset state is S_MAG.
  - S_MAG, strobe with `dig`=0: latch `seg_n` as the magnitude digit and go to S_SIGN.
  - S_MAG, strobe with `dig`=1: ignore it (resynchronisation).
  - S_SIGN, strobe with `dig`=0: overwrite the magnitude digit and stay in S_SIGN.
  - S_SIGN, strobe with `dig`=1: the frame is complete. Decode it and return to S_MAG.
- **Magnitude patterns**:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100.
  - 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000.
  - Any other pattern is illegal.
- **Sign patterns**: 1111111 = positive (blank), 1111110 = negative (g only). Any other pattern is illegal.
- **Legal frames**: positive with magnitude 0..7 gives value = magnitude. Negative with magnitude 1..8 gives value = (~magnitude + 1) mod 16. Negative zero and positive 8 are illegal.
- **Stability tracking** (4-bit run counter, 4-bit candidate):
  - Illegal frame: pulse `err`, clear the run counter, clear `locked`. `value` is held.
  - Legal frame equal to the candidate: run counter increments, saturating at `STABLE_CNT`.
  - Legal frame differing from the candidate: the candidate takes the new value and the run counter is set to 1.
  - When the run counter first reaches `STABLE_CNT`: set `locked`. If the candidate differs from `value`, load `value` and pulse `value_vld`. A frame equal to the already reported `value` does not re-pulse.
  - `STABLE_CNT`=1: every legal, changed frame reports immediately.

## Timing
- **Reset values**: `value`=0, `value_vld`=0, `err`=0, `locked`=0, `stale`=0. FSM is in S_MAG, run counter=0, candidate=0.
- **Latency**: `value_vld`/`err` assert in the cycle after the sign strobe that completes the frame. `value` is updated in that same cycle.
- **Strobes**: back-to-back strobes on consecutive cycles are supported. No backpressure; every strobe is consumed.
- **Reset mid-frame**: a partially captured frame is discarded.
- `value_vld` and `err` are mutually exclusive.

## Configuration
- **`SEG7_RD_TIMEOUT_EN` defined**:
  - A counter clears on every completed frame.
  - On reaching `TIMEOUT_CYC` with no completed frame, assert `stale`, clear `locked`, and clear the run counter.
  - The next completed legal frame deasserts `stale`.
- **`SEG7_RD_TIMEOUT_EN` undefined**: no counter is built, `stale` is tied 0, and `locked` persists indefinitely.

## Structure
- **Package `seg7_pkg`**:
  - Segment pattern constants `SEG_0`..`SEG_8`, `SEG_BLANK`, `SEG_MINUS`.
  - FSM state enum.
  - The digit width `SEG_W`=7.
- **Sub-module `seg7_digit_dec`**: combinational. Maps a 7-bit pattern to magnitude[3:0] plus a legal flag. Instantiated once for the magnitude digit.
- Sign classification is inline in the top.

## Test plan
- **Stable positive**: 3 frames (mag 0100100, sign 1111111) -> one `value_vld` with `value`=0101, `locked`=1 after the third frame.
- **Negative decode**: 3 frames (mag 0000110, sign 1111110) -> `value`=1101. Repeat with 0000000 -> `value`=1000.
- **Illegal pattern**: frame (mag 0000000, sign 1111111) -> `err` pulse, `locked`=0, `value` unchanged. A negative-zero frame also pulses `err`.
- **Flicker**: frames 3,3,4,3,3,3 -> a single `value_vld` (`value`=0011) on the 6th frame, and none for the 4.
- **Resync and reset**:
  - Sign strobe first, then mag 7, sign blank -> the leading sign strobe is ignored and 3 such frames report 0111.
  - `rst_n` low in S_SIGN -> all outputs return to 0.
- **With `SEG7_RD_TIMEOUT_EN`, `TIMEOUT_CYC`=16**: lock on 2, then idle 16 cycles -> `stale`=1, `locked`=0. The next legal frame clears `stale`.
